// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver with 2-flop input synchronizer and a first-word-fall-through byte FIFO.
module uart_rx_core #(
    parameter int CLK_FREQUENCY = 100_000,
    parameter int BAUD          = 256_000,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          rx_i,
    output logic [7:0]                    data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic                          frame_err_o,
    output logic                          overflow_o,
    input  logic                          clr_i,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o
);
    localparam int CLKS_PER_BIT = (CLK_FREQUENCY * 1000) / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int TW           = $clog2(CLKS_PER_BIT);
    localparam int AW           = $clog2(FIFO_DEPTH);
    localparam int CW           = AW + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    logic          sync1_q, rx_s_q;
    state_t        state_q;
    logic [TW-1:0] tick_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          frame_err_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    data_q, data_d;
    logic          ovf_q;
    logic          bit_done, push, pop, full, wr_en, ovf_set;

    assign bit_done = tick_q == TW'(CLKS_PER_BIT - 1);
    assign push     = state_q == STOP && bit_done && rx_s_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= IDLE;
            tick_q      <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            sync1_q     <= rx_i;
            rx_s_q      <= sync1_q;
            frame_err_q <= 1'b0;
            tick_q      <= tick_q + 1'b1;
            case (state_q)
                IDLE: begin
                    tick_q    <= '0;
                    bit_cnt_q <= '0;
                    if (!rx_s_q) state_q <= START;
                end
                START: if (tick_q == TW'(HALF_BIT - 1)) begin
                    tick_q  <= '0;
                    state_q <= rx_s_q ? IDLE : DATA;
                end
                DATA: if (bit_done) begin
                    tick_q             <= '0;
                    shift_q[bit_cnt_q] <= rx_s_q;
                    bit_cnt_q          <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_q <= STOP;
                end
                STOP: if (bit_done) begin
                    tick_q      <= '0;
                    state_q     <= rx_s_q ? IDLE : WAIT_IDLE;
                    frame_err_q <= !rx_s_q;
                end
                WAIT_IDLE: begin
                    tick_q <= '0;
                    if (rx_s_q) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // data_d tracks the head after this cycle's push/pop; a push into an empty (or emptying) FIFO becomes the head directly
    always_comb begin
        pop     = count_q != '0 && ready_i;
        full    = count_q == CW'(FIFO_DEPTH);
        wr_en   = push && (!full || pop);
        ovf_set = push && full && !pop;
        rd_d    = rd_q + AW'(pop);
        count_d = count_q + CW'(wr_en) - CW'(pop);
        data_d  = count_d == '0 ? data_q : count_q == CW'(pop) ? shift_q : mem_q[rd_d];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (wr_en) mem_q[wr_q] <= shift_q;
            wr_q    <= wr_q + AW'(wr_en);
            rd_q    <= rd_d;
            count_q <= count_d;
            data_q  <= data_d;
            ovf_q   <= ovf_set || (ovf_q && !clr_i);
        end
    end

    assign data_o      = data_q;
    assign valid_o     = count_q != '0;
    assign frame_err_o = frame_err_q;
    assign overflow_o  = ovf_q;
    assign busy_o      = state_q != IDLE;
    assign count_o     = count_q;
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: table-driven, directed and randomized checks of uart_rx_core against a queue-based frame model.
module tb_uart_rx_core;
    localparam int CPB  = 10;
    localparam int HALF = 5;
    localparam int LAT  = 2 + CPB - HALF + 1;

    logic       clk = 1'b0;
    logic       rst_i, rx_i, ready_i, clr_i;
    logic [7:0] data_o;
    logic       valid_o, frame_err_o, overflow_o, busy_o;
    logic [2:0] count_o;

    uart_rx_core #(.CLK_FREQUENCY(1000), .BAUD(100_000), .FIFO_DEPTH(4)) dut (
        .clk_i(clk), .rst_i(rst_i), .rx_i(rx_i), .data_o(data_o), .valid_o(valid_o),
        .ready_i(ready_i), .frame_err_o(frame_err_o), .overflow_o(overflow_o),
        .clr_i(clr_i), .busy_o(busy_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    int         checks = 0, failures = 0, err_cnt = 0, stop_cyc = 0, rise_cyc = 0;
    logic       prev_valid = 1'b0;
    bit         rand_ready = 1'b0;
    logic [7:0] got[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_err_o) err_cnt++;
        if (valid_o && !prev_valid) rise_cyc = cyc;
        prev_valid = valid_o;
        if (valid_o && ready_i) got.push_back(data_o);
    end

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        rx_i = v;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rand_ready) ready_i = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_val, input int stop_len);
        @(posedge clk);
        #1;
        drive(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive(b[i], CPB);
        stop_cyc = cyc;
        drive(stop_val, stop_len);
        rx_i = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_val;
        int         stop_len;
        int         exp_push;
        int         exp_err;
    } vec_t;

    vec_t       tbl[5];
    logic [7:0] bb[3];
    logic [7:0] ov[5];
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int         n0, e0, d, exp_err;
    bit         ok;

    initial begin
        tbl[0] = '{8'hA5, 1'b1, CPB, 1, 0};
        tbl[1] = '{8'h00, 1'b1, CPB, 1, 0};
        tbl[2] = '{8'hFF, 1'b1, CPB, 1, 0};
        tbl[3] = '{8'h55, 1'b0, 30,  0, 1};
        tbl[4] = '{8'h12, 1'b1, CPB, 1, 0};
        bb = '{8'h00, 8'hFF, 8'h3C};
        ov = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        rst_i = 1'b1; rx_i = 1'b1; ready_i = 1'b0; clr_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        chk("rst_valid", valid_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_ferr", frame_err_o, 0);
        chk("rst_ovf", overflow_o, 0);
        chk("rst_busy", busy_o, 0);

        ready_i = 1'b1;
        foreach (tbl[i]) begin
            n0 = got.size(); e0 = err_cnt;
            send_frame(tbl[i].data, tbl[i].stop_val, tbl[i].stop_len);
            drive(1'b1, 20);
            chk("tbl_push", got.size() - n0, tbl[i].exp_push);
            chk("tbl_err", err_cnt - e0, tbl[i].exp_err);
            chk("tbl_busy", busy_o, 0);
            if (tbl[i].exp_push != 0 && got.size() > n0) begin
                chk("tbl_data", got[n0], tbl[i].data);
                d = rise_cyc - stop_cyc;
                chk("tbl_latency", (d >= LAT - 1 && d <= LAT + 1) ? LAT : d, LAT);
            end
        end

        ready_i = 1'b0; n0 = got.size();
        for (int i = 0; i < 3; i++) begin
            send_frame(bb[i], 1'b1, CPB);
            chk("b2b_count", count_o, i + 1);
        end
        ready_i = 1'b1;
        drive(1'b1, 10);
        chk("b2b_n", got.size() - n0, 3);
        for (int i = 0; i < 3; i++) if (got.size() > n0 + i) chk("b2b_data", got[n0 + i], bb[i]);
        chk("b2b_empty", count_o, 0);

        n0 = got.size(); e0 = err_cnt;
        @(posedge clk);
        #1;
        drive(1'b0, 3);
        drive(1'b1, 2);
        chk("glitch_busy_hi", busy_o, 1);
        drive(1'b1, 20);
        chk("glitch_busy_lo", busy_o, 0);
        chk("glitch_push", got.size() - n0, 0);
        chk("glitch_err", err_cnt - e0, 0);

        ready_i = 1'b0; n0 = got.size();
        for (int i = 0; i < 5; i++) send_frame(ov[i], 1'b1, CPB);
        drive(1'b1, 3);
        chk("ovf_count", count_o, 4);
        chk("ovf_set", overflow_o, 1);
        clr_i = 1'b1;
        drive(1'b1, 1);
        clr_i = 1'b0;
        @(negedge clk);
        chk("ovf_clr", overflow_o, 0);
        @(posedge clk);
        #1 ready_i = 1'b1;
        drive(1'b1, 10);
        chk("ovf_n", got.size() - n0, 4);
        for (int i = 0; i < 4; i++) if (got.size() > n0 + i) chk("ovf_data", got[n0 + i], ov[i]);

        ready_i = 1'b0;
        send_frame(8'h99, 1'b1, CPB);
        chk("pre_rst_count", count_o, 1);
        b = 8'h81;
        @(posedge clk);
        #1;
        drive(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive(b[i], CPB);
        rst_i = 1'b1; rx_i = 1'b1;
        @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", valid_o, 0);
        chk("mid_rst_count", count_o, 0);
        chk("mid_rst_data", data_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_ferr", frame_err_o, 0);
        ready_i = 1'b1; n0 = got.size();
        send_frame(8'h7E, 1'b1, CPB);
        drive(1'b1, 20);
        chk("post_rst_n", got.size() - n0, 1);
        if (got.size() > n0) chk("post_rst_data", got[n0], 8'h7E);

        n0 = got.size(); e0 = err_cnt; exp_err = 0;
        rand_ready = 1'b1;
        repeat (25) begin
            b  = 8'($urandom);
            ok = $urandom_range(0, 4) != 0;
            send_frame(b, ok, CPB);
            if (ok) exp_q.push_back(b);
            else exp_err++;
            drive(1'b1, ok ? $urandom_range(0, 6) : 6 + $urandom_range(0, 6));
        end
        rand_ready = 1'b0;
        ready_i = 1'b1;
        drive(1'b1, 20);
        chk("rand_n", got.size() - n0, exp_q.size());
        foreach (exp_q[i]) if (got.size() > n0 + i) chk("rand_data", got[n0 + i], exp_q[i]);
        chk("rand_err", err_cnt - e0, exp_err);
        chk("rand_ovf", overflow_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
